// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and sizing helpers for the PLL lock sequencer
// Purpose: sequencer state encoding, attempt-counter width and cycle-counter width helper.
// Ports: none (package).
package pll_seq_pkg;

  localparam int ATTEMPT_W = 4;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // Counter width: enough bits for the largest cycle parameter, plus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width two-flop synchronizer
// Purpose: bring an asynchronous level into the i_clk domain with two cycles of latency.
// Ports:
//   i_clk  in  1      destination clock
//   i_rst  in  1      synchronous active-high reset (flops clear to 0)
//   i_d    in  WIDTH  asynchronous input
//   o_q    out WIDTH  synchronized output
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock supervisor driving the downstream reset tree
// Purpose: pulse the PLL reset, wait for a synchronized lock, qualify it as stable, then
//   release sys_rst. Retries on lock timeout, faults after MAX_RETRIES extra attempts,
//   re-sequences on lock loss or restart. Optional macro PLL_LOCK_LOSS_COUNT_EN adds loss_cnt.
// Ports:
//   refclk      in  1  reference clock (sole clock)
//   rst         in  1  synchronous active-high reset
//   pll_locked  in  1  PLL lock, asynchronous to refclk
//   restart     in  1  single-cycle re-sequence request, also clears FAULT
//   pll_rst     out 1  PLL reset
//   sys_rst     out 1  downstream reset, active high
//   ready       out 1  high only in RUN
//   fault       out 1  high only in FAULT
//   loss_cnt    out 8  saturating count of lock losses in RUN (PLL_LOCK_LOSS_COUNT_EN only)
//   attempt     out 4  current attempt index
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 7
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 restart,
  output logic                 pll_rst,
  output logic                 sys_rst,
  output logic                 ready,
  output logic                 fault,
`ifdef PLL_LOCK_LOSS_COUNT_EN
  output logic [7:0]           loss_cnt,
`endif
  output logic [ATTEMPT_W-1:0] attempt
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam logic [CNT_W-1:0]     RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]     STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [ATTEMPT_W-1:0] ATT_MAX  = ATTEMPT_W'(MAX_RETRIES);

  pll_state_e           r_state;
  pll_state_e           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     r_tmo_cnt;
  logic [CNT_W-1:0]     w_tmo_nxt;
  logic [CNT_W-1:0]     w_tmo_adv;
  logic [ATTEMPT_W-1:0] r_attempt;
  logic [ATTEMPT_W-1:0] w_attempt_nxt;
  logic                 r_pll_rst;
  logic                 r_sys_rst;
  logic                 r_ready;
  logic                 r_fault;
  logic                 w_pll_rst_nxt;
  logic                 w_sys_rst_nxt;
  logic                 w_ready_nxt;
  logic                 w_fault_nxt;
  logic                 w_lk;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic                 w_loss_inc;
  logic [7:0]           r_loss_cnt;
`endif

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_lk)
  );

  // The lock-wait window spans WAIT_LOCK and STABLE together, so a lock that keeps
  // glitching out of STABLE still exhausts the attempt. It saturates at its last count.
  assign w_tmo_adv = (r_tmo_cnt == TMO_LAST) ? r_tmo_cnt : r_tmo_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo_cnt;
    w_attempt_nxt = r_attempt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    w_loss_inc    = 1'b0;
`endif
    if (restart) begin
      w_state_nxt   = RESET_PLL;
      w_cnt_nxt     = '0;
      w_tmo_nxt     = '0;
      w_attempt_nxt = '0;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (w_lk) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = w_tmo_adv;
          end else if (r_tmo_cnt == TMO_LAST) begin
            w_cnt_nxt = '0;
            if (r_attempt < ATT_MAX) begin
              w_state_nxt   = RESET_PLL;
              w_attempt_nxt = r_attempt + ATTEMPT_W'(1);
            end else begin
              w_state_nxt = FAULT;
            end
          end else begin
            w_tmo_nxt = w_tmo_adv;
          end
        end
        STABLE: begin
          w_tmo_nxt = w_tmo_adv;
          if (!w_lk) begin
            w_state_nxt = WAIT_LOCK;
          end else if (r_cnt == STB_LAST) begin
            w_state_nxt   = RUN;
            w_attempt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!w_lk) begin
            w_state_nxt = RESET_PLL;
            w_cnt_nxt   = '0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
            w_loss_inc  = 1'b1;
`endif
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = RESET_PLL;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they change on the same
  // edge as the state and never combinationally follow pll_locked or restart.
  always_comb begin
    w_pll_rst_nxt = 1'b1;
    w_sys_rst_nxt = 1'b1;
    w_ready_nxt   = 1'b0;
    w_fault_nxt   = 1'b0;
    case (w_state_nxt)
      WAIT_LOCK, STABLE: w_pll_rst_nxt = 1'b0;
      RUN: begin
        w_pll_rst_nxt = 1'b0;
        w_sys_rst_nxt = 1'b0;
        w_ready_nxt   = 1'b1;
      end
      FAULT:   w_fault_nxt = 1'b1;
      default: w_pll_rst_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= RESET_PLL;
      r_cnt     <= '0;
      r_tmo_cnt <= '0;
      r_attempt <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_attempt <= w_attempt_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_ready   <= w_ready_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

  assign pll_rst = r_pll_rst;
  assign sys_rst = r_sys_rst;
  assign ready   = r_ready;
  assign fault   = r_fault;
  assign attempt = r_attempt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  localparam int LIMIT = 8000;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] attempt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt;
`endif

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #10 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (16),
    .LOCK_TIMEOUT_CYC (4096),
    .LOCK_STABLE_CYC  (1024),
    .MAX_RETRIES      (7)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
`ifdef PLL_LOCK_LOSS_COUNT_EN
    .loss_cnt   (loss_cnt),
`endif
    .attempt    (attempt)
  );

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    n_total++;
    assert (sb.size() != 0) else begin
      $error("FAIL scoreboard_empty: observed %0d expected <queued entry>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
  endtask

  // {pll_rst, sys_rst, ready, fault, attempt[3:0]}
  function automatic int outs();
    return int'({pll_rst, sys_rst, ready, fault, attempt});
  endfunction

  // Number of consecutive samples, starting with the current one, where pll_rst == level.
  task automatic count_while(input logic level, output int n);
    n = 0;
    while (pll_rst === level && n < LIMIT) begin
      n++;
      step();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst        = 1'b1;
    restart    = 1'b0;
    pll_locked = 1'b0;
    repeat (3) step();
    expect_val("reset_outputs", 'hC0);
    check(outs());

    // Normal bring-up
    rst = 1'b0;
    expect_val("bringup_pll_rst_width", 16);
    count_while(1'b1, n);
    check(n);
    // pll_rst fell at edge F; pll_locked first sampled at F+100, lk at F+101,
    // STABLE from F+102, release 1024 edges later.
    repeat (99) step();
    pll_locked = 1'b1;
    n = 99;
    while (sys_rst === 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
    expect_val("bringup_release_delay", 102 + 1024);
    check(n);
    expect_val("bringup_run_outputs", 'h20);
    check(outs());

    // Lock loss in RUN: two synchronizer edges plus the FSM edge
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst === 1'b0 && n < 64) begin
      step();
      n++;
    end
    expect_val("loss_reassert_delay", 3);
    check(n);
    expect_val("loss_outputs", 'hC0);
    check(outs());
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expect_val("loss_cnt_after_loss", 1);
    check(int'(loss_cnt));
`endif
    expect_val("loss_pll_rst_width", 16);
    count_while(1'b1, n);
    check(n);

    // Lock glitch in STABLE: STABLE from F2+3, one-cycle drop sampled at F2+504,
    // back to WAIT_LOCK at F2+506, STABLE again at F2+507, release at F2+1531.
    pll_locked = 1'b1;
    repeat (503) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 504;
    while (sys_rst === 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
    expect_val("glitch_release_delay", 507 + 1024);
    check(n);

    // Restart from RUN does not count as a lock loss
    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_val("restart_from_run_outputs", 'hC0);
    check(outs());
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expect_val("loss_cnt_after_restart", 1);
    check(int'(loss_cnt));
`endif
    expect_val("restart_pll_rst_width", 16);
    count_while(1'b1, n);
    check(n);

    // lk is already 1: STABLE from F3+1, the completing edge is F3+1025; restart lands on it.
    repeat (1024) step();
    restart    = 1'b1;
    pll_locked = 1'b0;
    step();
    restart = 1'b0;
    expect_val("simultaneous_restart_outputs", 'hC0);
    check(outs());
    expect_val("simultaneous_pll_rst_width", 16);
    count_while(1'b1, n);
    check(n);

    // Mid-operation reset inside WAIT_LOCK
    repeat (3000) step();
    rst = 1'b1;
    step();
    expect_val("midop_reset_outputs", 'hC0);
    check(outs());
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expect_val("midop_reset_loss_cnt", 0);
    check(int'(loss_cnt));
`endif
    rst = 1'b0;

    // Timeout / retry with lock held low
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("retry%0d_attempt", i), i);
      check(int'(attempt));
      expect_val($sformatf("retry%0d_pll_rst_width", i), 16);
      count_while(1'b1, n);
      check(n);
      expect_val($sformatf("retry%0d_wait_width", i), 4096);
      count_while(1'b0, n);
      check(n);
    end
    expect_val("fault_outputs", 'hD7);
    check(outs());
    repeat (50) step();
    expect_val("fault_held_outputs", 'hD7);
    check(outs());

    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_val("fault_restart_outputs", 'hC0);
    check(outs());
    expect_val("fault_restart_pll_rst_width", 16);
    count_while(1'b1, n);
    check(n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
